dc_block_avg: RTL and testbench

- Multi-channel, parametrised moving-average DC remover. Successor to the fixed 128-sample, single-channel average stage in the FM demodulator chain.
- Each accepted sample vector has its per-channel running mean (window of 2^LOG2_DEPTH samples, current sample included) subtracted.
- Adds valid handshaking, warm-up tracking, flush, bypass and output saturation.
- Sits between the I/Q merge stage and the demodulator core; one channel per I/Q component.

---
 rtl/dc_block_avg.sv | 100 ++++++++++
 tb/tb_dc_block_avg.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dc_block_avg.sv
// Multi-channel moving-average DC remover: subtracts a per-channel running mean
// over a 2^LOG2_DEPTH sample window, with flush, bypass and output saturation.
module dc_block_avg #(
  parameter int WIDTH      = 16,
  parameter int LOG2_DEPTH = 7,
  parameter int CHANNELS   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  input  logic                      bypass_i,
  input  logic                      flush_i,
  output logic                      valid_o,
  output logic [CHANNELS*WIDTH-1:0] data_o,
  output logic [CHANNELS*WIDTH-1:0] mean_o,
  output logic                      primed_o
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = WIDTH + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] FILL_MAX  = (LOG2_DEPTH+1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0] FILL_LAST = FILL_MAX - 1'b1;

  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH:0]   fill;
  logic                  full;
  logic                  accept;

  assign accept = valid_i && !flush_i;
  assign full   = (fill == FILL_MAX);

  // Shared pointer, fill level and handshake; flush beats a simultaneous sample.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr   <= '0;
      fill     <= '0;
      valid_o  <= 1'b0;
      primed_o <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        wr_ptr   <= wr_ptr + 1'b1;
        if (!full) fill <= fill + 1'b1;
        primed_o <= (fill >= FILL_LAST);
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [WIDTH-1:0] mem [DEPTH];
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] old;
    logic signed [WIDTH-1:0] mean;
    logic signed [WIDTH-1:0] sat;
    logic signed [WIDTH-1:0] data_q;
    logic signed [WIDTH-1:0] mean_q;
    logic signed [SW-1:0]    sum_q;
    logic signed [SW-1:0]    sum_new;
    logic signed [WIDTH:0]   diff;

    assign x       = data_i[c*WIDTH +: WIDTH];
    // Slots not yet written since reset/flush count as zero, never stale RAM.
    assign old     = full ? mem[wr_ptr] : '0;
    assign sum_new = sum_q - SW'(old) + SW'(x);
    assign mean    = WIDTH'(sum_new >>> LOG2_DEPTH);
    assign diff    = (WIDTH+1)'(x) - (WIDTH+1)'(mean);

    always_comb begin
      sat = diff[WIDTH-1:0];
      if (diff[WIDTH] != diff[WIDTH-1])
        sat = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    // NOTE: the sample buffer has no reset so it can map onto block RAM; the
    // fill count alone decides whether a slot's contents are meaningful.
    always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= x;
    end

    always_ff @(posedge clk) begin
      if (rst || flush_i) sum_q <= '0;
      else if (accept)    sum_q <= sum_new;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q <= '0;
        mean_q <= '0;
      end else if (accept) begin
        data_q <= bypass_i ? x : sat;
        mean_q <= mean;
      end
    end

    assign data_o[c*WIDTH +: WIDTH] = data_q;
    assign mean_o[c*WIDTH +: WIDTH] = mean_q;
  end

endmodule

// File: tb/tb_dc_block_avg.sv
// Directed bench for dc_block_avg at WIDTH=16, LOG2_DEPTH=3, CHANNELS=2 with
// hand-computed expected outputs.
module tb_dc_block_avg;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] data_i;
  logic        bypass_i;
  logic        flush_i;
  logic        valid_o;
  logic [31:0] data_o;
  logic [31:0] mean_o;
  logic        primed_o;

  int total  = 0;
  int passed = 0;

  dc_block_avg #(.WIDTH(16), .LOG2_DEPTH(3), .CHANNELS(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .data_i   (data_i),
    .bypass_i (bypass_i),
    .flush_i  (flush_i),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .mean_o   (mean_o),
    .primed_o (primed_o)
  );

  always #5 clk = ~clk;

  function automatic logic signed [15:0] ch(input logic [31:0] v, input int c);
    return v[c*16 +: 16];
  endfunction

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic step(input logic v, input logic signed [15:0] x0,
                      input logic signed [15:0] x1, input logic byp,
                      input logic fl, input logic r);
    valid_i  = v;
    data_i   = {x1, x0};
    bypass_i = byp;
    flush_i  = fl;
    rst      = r;
    @(posedge clk); #1;
    valid_i  = 1'b0;
    flush_i  = 1'b0;
    rst      = 1'b0;
    bypass_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; data_i = '0; bypass_i = 1'b0; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (valid_o !== 1'b0 || primed_o !== 1'b0 || data_o !== 32'h0 || mean_o !== 32'h0)
      $display("FAIL reset: valid=%b primed=%b data=%h mean=%h, need all zero",
               valid_o, primed_o, data_o, mean_o);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_warmup();
    for (int k = 1; k <= 10; k++) begin
      int ed, em;
      step(1'b1, 16'sd1000, 16'sd0, 1'b0, 1'b0, 1'b0);
      ed = (k <= 8) ? 1000 - 125*k : 0;
      em = (k <= 8) ? 125*k : 1000;
      total++;
      if (valid_o !== 1'b1) $display("FAIL warm valid k=%0d got %b need 1", k, valid_o);
      else passed++;
      total++;
      if (ch(data_o,0) != ed) $display("FAIL warm data k=%0d got %0d need %0d", k, ch(data_o,0), ed);
      else passed++;
      total++;
      if (ch(mean_o,0) != em) $display("FAIL warm mean k=%0d got %0d need %0d", k, ch(mean_o,0), em);
      else passed++;
      total++;
      if (primed_o !== (k >= 8)) $display("FAIL warm primed k=%0d got %b need %b", k, primed_o, k >= 8);
      else passed++;
    end
  endtask

  task automatic test_neg_floor();
    int em [4] = '{-1, -1, -2, -2};
    int ed [4] = '{-2, -2, -1, -1};
    step(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 16'sd0, -16'sd3, 1'b0, 1'b0, 1'b0);
      total++;
      if (ch(mean_o,1) != em[k] || ch(data_o,1) != ed[k])
        $display("FAIL neg_floor n=%0d got mean %0d data %0d need mean %0d data %0d",
                 k+1, ch(mean_o,1), ch(data_o,1), em[k], ed[k]);
      else passed++;
    end
  endtask

  task automatic test_saturation();
    step(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b1, 1'b0);
    repeat (7) step(1'b1, -16'sd32768, 16'sd32767, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'sd32767, -16'sd32768, 1'b0, 1'b0, 1'b0);
    total++;
    if (ch(mean_o,0) != -24577 || ch(data_o,0) != 32767)
      $display("FAIL sat_pos got mean %0d data %0d need mean -24577 data 32767",
               ch(mean_o,0), ch(data_o,0));
    else passed++;
    total++;
    if (ch(mean_o,1) != 24575 || ch(data_o,1) != -32768)
      $display("FAIL sat_neg got mean %0d data %0d need mean 24575 data -32768",
               ch(mean_o,1), ch(data_o,1));
    else passed++;
  endtask

  task automatic test_wrap();
    step(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b1, 1'b0);
    repeat (8) step(1'b1, 16'sd100, 16'sd0, 1'b0, 1'b0, 1'b0);
    total++;
    if (primed_o !== 1'b1 || ch(mean_o,0) != 100)
      $display("FAIL wrap_prime got primed %b mean %0d need 1 and 100", primed_o, ch(mean_o,0));
    else passed++;
    for (int k = 1; k <= 8; k++) begin
      int gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        total++;
        if (valid_o !== 1'b0) $display("FAIL wrap_gap k=%0d got valid %b need 0", k, valid_o);
        else passed++;
      end
      step(1'b1, 16'sd300, 16'sd0, 1'b0, 1'b0, 1'b0);
      total++;
      if (valid_o !== 1'b1 || ch(mean_o,0) != 100 + 25*k || ch(data_o,0) != 200 - 25*k)
        $display("FAIL wrap k=%0d got valid %b mean %0d data %0d need 1 %0d %0d",
                 k, valid_o, ch(mean_o,0), ch(data_o,0), 100 + 25*k, 200 - 25*k);
      else passed++;
    end
  endtask

  task automatic test_flush_collision();
    step(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b1, 1'b0);
    repeat (8) step(1'b1, 16'sd200, 16'sd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'sd999, 16'sd0, 1'b0, 1'b1, 1'b0);
    total++;
    if (valid_o !== 1'b0 || primed_o !== 1'b0)
      $display("FAIL flush_coll got valid %b primed %b need 0 0", valid_o, primed_o);
    else passed++;
    total++;
    if (ch(data_o,0) != 0 || ch(mean_o,0) != 200)
      $display("FAIL flush_hold got data %0d mean %0d need 0 200", ch(data_o,0), ch(mean_o,0));
    else passed++;
    step(1'b1, 16'sd1000, 16'sd0, 1'b0, 1'b0, 1'b0);
    total++;
    if (valid_o !== 1'b1 || ch(data_o,0) != 875 || ch(mean_o,0) != 125 || primed_o !== 1'b0)
      $display("FAIL flush_after got valid %b data %0d mean %0d primed %b need 1 875 125 0",
               valid_o, ch(data_o,0), ch(mean_o,0), primed_o);
    else passed++;
  endtask

  task automatic test_reset_midstream();
    repeat (8) step(1'b1, 16'sd200, 16'sd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'sd999, 16'sd0, 1'b0, 1'b0, 1'b1);
    total++;
    if (valid_o !== 1'b0 || primed_o !== 1'b0 || data_o !== 32'h0 || mean_o !== 32'h0)
      $display("FAIL rst_mid got valid %b primed %b data %h mean %h need all zero",
               valid_o, primed_o, data_o, mean_o);
    else passed++;
    step(1'b1, 16'sd1000, 16'sd0, 1'b0, 1'b0, 1'b0);
    total++;
    if (valid_o !== 1'b1 || ch(data_o,0) != 875 || ch(mean_o,0) != 125)
      $display("FAIL rst_after got valid %b data %0d mean %0d need 1 875 125",
               valid_o, ch(data_o,0), ch(mean_o,0));
    else passed++;
  endtask

  task automatic test_bypass();
    step(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b1, 1'b0);
    repeat (8) step(1'b1, 16'sd500, 16'sd0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      logic byp;
      int ed;
      byp = (k % 2) == 1;
      step(1'b1, 16'sd700, 16'sd0, byp, 1'b0, 1'b0);
      ed = byp ? 700 : 200 - 25*k;
      total++;
      if (ch(data_o,0) != ed || ch(mean_o,0) != 500 + 25*k)
        $display("FAIL bypass k=%0d got data %0d mean %0d need %0d %0d",
                 k, ch(data_o,0), ch(mean_o,0), ed, 500 + 25*k);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_neg_floor();
    test_saturation();
    test_wrap();
    test_flush_collision();
    test_reset_midstream();
    test_bypass();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
